// File: rtl/vga_pkg.sv
// Shared 640x480 VGA timing constants and the pattern selector type.
package vga_pkg;

  localparam int H_VISIBLE    = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 751;
  localparam int H_TOTAL      = 800;
  localparam int V_VISIBLE    = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 491;
  localparam int V_TOTAL      = 525;

  typedef enum logic [1:0] {
    PAT_STRIPES = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_BLANK   = 2'd3
  } pat_t;

  // BLANK rolls over to STRIPES through the natural 2-bit wrap.
  function automatic pat_t pat_next(input pat_t p);
    return pat_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel divider, raster counters and registered sync/video-enable/frame strobes.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_VIS    = H_VISIBLE,
  parameter int H_SYNC_S = H_SYNC_START,
  parameter int H_SYNC_E = H_SYNC_END,
  parameter int H_TOT    = H_TOTAL,
  parameter int V_VIS    = V_VISIBLE,
  parameter int V_SYNC_S = V_SYNC_START,
  parameter int V_SYNC_E = V_SYNC_END,
  parameter int V_TOT    = V_TOTAL
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       hsync,
  output logic       vsync,
  output logic       vidon,
  output logic       pix_tick,
  output logic       frame_start
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]      H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0]      V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0]      HV       = 10'(H_VIS);
  localparam logic [9:0]      HSS      = 10'(H_SYNC_S);
  localparam logic [9:0]      HSE      = 10'(H_SYNC_E);
  localparam logic [9:0]      VV       = 10'(V_VIS);
  localparam logic [9:0]      VSS      = 10'(V_SYNC_S);
  localparam logic [9:0]      VSE      = 10'(V_SYNC_E);

  logic [DIV_W-1:0] div;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;
  logic [9:0]       hc_nxt;
  logic [9:0]       vc_nxt;

  assign tick   = (div == DIV_LAST);
  assign h_wrap = (hc == H_LAST);
  assign v_wrap = (vc == V_LAST);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hc_nxt = hc;
    vc_nxt = vc;
    if (tick) begin
      hc_nxt = h_wrap ? 10'd0 : hc + 10'd1;
      if (h_wrap) vc_nxt = v_wrap ? 10'd0 : vc + 10'd1;
    end
  end

  // Decodes use the next counter values so each flag lines up with the hc/vc it describes.
  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      hc          <= '0;
      vc          <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      vidon       <= 1'b1;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= tick ? '0 : div + DIV_W'(1);
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      pix_tick    <= tick;
      frame_start <= tick & h_wrap & v_wrap;
      vidon       <= (hc_nxt < HV) && (vc_nxt < VV);
      hsync       <= !((hc_nxt >= HSS) && (hc_nxt <= HSE));
      vsync       <= !((vc_nxt >= VSS) && (vc_nxt <= VSE));
    end
  end

endmodule

// File: rtl/vga_frame_sequencer.sv
// VGA raster timing plus a frame-synchronous pattern selector (manual or auto-cycling).
module vga_frame_sequencer
  import vga_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int DWELL_FRAMES = 120,
  parameter int H_VIS        = H_VISIBLE,
  parameter int H_SYNC_S     = H_SYNC_START,
  parameter int H_SYNC_E     = H_SYNC_END,
  parameter int H_TOT        = H_TOTAL,
  parameter int V_VIS        = V_VISIBLE,
  parameter int V_SYNC_S     = V_SYNC_START,
  parameter int V_SYNC_E     = V_SYNC_END,
  parameter int V_TOT        = V_TOTAL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       auto_en,
  input  logic       next_req,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       hsync,
  output logic       vsync,
  output logic       vidon,
  output logic       pix_tick,
  output logic       frame_start,
  output logic [1:0] pat_sel
);

  localparam int                 DWELL_W    = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);

  pat_t               state;
  pat_t               state_nxt;
  logic               req_q;
  logic               req_edge;
  logic               pending;
  logic               advance;
  logic [DWELL_W-1:0] dwell_cnt;

  vga_timing #(
    .CLK_DIV (CLK_DIV),
    .H_VIS   (H_VIS),
    .H_SYNC_S(H_SYNC_S),
    .H_SYNC_E(H_SYNC_E),
    .H_TOT   (H_TOT),
    .V_VIS   (V_VIS),
    .V_SYNC_S(V_SYNC_S),
    .V_SYNC_E(V_SYNC_E),
    .V_TOT   (V_TOT)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .hc         (hc),
    .vc         (vc),
    .hsync      (hsync),
    .vsync      (vsync),
    .vidon      (vidon),
    .pix_tick   (pix_tick),
    .frame_start(frame_start)
  );

  // Uses the registered pending flag, so an edge in the frame_start clock waits a frame.
  assign req_edge = next_req & ~req_q;
  assign advance  = frame_start & (pending | (auto_en & (dwell_cnt == DWELL_LAST)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= 1'b0;
      pending   <= 1'b0;
      dwell_cnt <= '0;
    end else begin
      req_q   <= next_req;
      pending <= req_edge | (pending & ~advance);
      if (!auto_en || advance) dwell_cnt <= '0;
      else if (frame_start)    dwell_cnt <= dwell_cnt + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PAT_STRIPES;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (advance) state_nxt = pat_next(state);
  end

  assign pat_sel = state;

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Bench: real-geometry instance for line timing, reduced-geometry instance for frame/pattern behaviour.
module tb_vga_frame_sequencer;

  localparam int unsigned DIV   = 2;
  localparam int unsigned DWELL = 2;

  typedef struct packed {
    int unsigned hv, hss, hse, ht, vv, vss, vse, vt;
  } geom_t;

  typedef struct packed {
    logic [9:0] hc;
    logic [9:0] vc;
    logic       hs;
    logic       vs;
    logic       vid;
    logic       pt;
    logic       fs;
  } tim_t;

  typedef struct {
    int unsigned cyc;
    tim_t        exp;
  } vec_t;

  localparam geom_t BIG  = '{640, 656, 751, 800, 480, 490, 491, 525};
  localparam geom_t MINI = '{16, 18, 21, 24, 6, 7, 8, 10};
  localparam int unsigned MINI_FRAME = MINI.ht * MINI.vt * DIV;
  localparam tim_t RST_TIM = '{10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  logic       clk, rst_n, auto_en, next_req, tie0;
  logic [9:0] b_hc, b_vc, m_hc, m_vc;
  logic       b_hs, b_vs, b_vid, b_pt, b_fs, m_hs, m_vs, m_vid, m_pt, m_fs;
  logic [1:0] b_pat, m_pat_sel;
  tim_t       bi, mi;

  assign tie0 = 1'b0;
  assign bi = {b_hc, b_vc, b_hs, b_vs, b_vid, b_pt, b_fs};
  assign mi = {m_hc, m_vc, m_hs, m_vs, m_vid, m_pt, m_fs};

  vga_frame_sequencer #(.CLK_DIV(DIV)) u_big (
    .clk(clk), .rst_n(rst_n), .auto_en(tie0), .next_req(tie0),
    .hc(b_hc), .vc(b_vc), .hsync(b_hs), .vsync(b_vs), .vidon(b_vid),
    .pix_tick(b_pt), .frame_start(b_fs), .pat_sel(b_pat)
  );

  vga_frame_sequencer #(
    .CLK_DIV(DIV), .DWELL_FRAMES(DWELL),
    .H_VIS(16), .H_SYNC_S(18), .H_SYNC_E(21), .H_TOT(24),
    .V_VIS(6), .V_SYNC_S(7), .V_SYNC_E(8), .V_TOT(10)
  ) u_mini (
    .clk(clk), .rst_n(rst_n), .auto_en(auto_en), .next_req(next_req),
    .hc(m_hc), .vc(m_vc), .hsync(m_hs), .vsync(m_vs), .vidon(m_vid),
    .pix_tick(m_pt), .frame_start(m_fs), .pat_sel(m_pat_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n;
  int          vectors, miscompares;
  int          mdl_pat, mdl_frames;
  bit          mdl_pend, mdl_nr_last;
  int          hs_low_l1, vid_l1, mini_fs_seen, mini_vid_cnt;
  int unsigned last_fs_n;
  vec_t        tbl [14];
  int          exp_pat [16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, n);
    end
  endtask

  // Raster position follows directly from elapsed clocks: pixel = (clocks / DIV) mod frame size.
  function automatic tim_t tim_model(input int unsigned cyc, input geom_t g);
    int unsigned p, h, v;
    tim_t t;
    p     = (cyc / DIV) % (g.ht * g.vt);
    h     = p % g.ht;
    v     = p / g.ht;
    t.hc  = h[9:0];
    t.vc  = v[9:0];
    t.pt  = (cyc != 0) && (cyc % DIV == 0);
    t.fs  = t.pt && (p == 0);
    t.vid = (h < g.hv) && (v < g.vv);
    t.hs  = !(h >= g.hss && h <= g.hse);
    t.vs  = !(v >= g.vss && v <= g.vse);
    return t;
  endfunction

  // Pattern rules at a frame boundary: a request seen before this frame's end, or the dwell expiring.
  task automatic model_edge(input bit ae, input bit nr);
    bit frame_end, rising;
    frame_end   = tim_model(n, MINI).fs;
    rising      = nr && !mdl_nr_last;
    mdl_nr_last = nr;
    if (frame_end && (mdl_pend || (ae && mdl_frames == int'(DWELL) - 1))) begin
      mdl_pat    = (mdl_pat + 1) % 4;
      mdl_pend   = 1'b0;
      mdl_frames = 0;
    end else if (!ae) begin
      mdl_frames = 0;
    end else if (frame_end) begin
      mdl_frames++;
    end
    if (rising) mdl_pend = 1'b1;
  endtask

  task automatic step();
    bit ae_c, nr_c;
    ae_c = auto_en;
    nr_c = next_req;
    @(posedge clk);
    #1;
    model_edge(ae_c, nr_c);
    n++;
    check("big_timing", 32'(bi), 32'(tim_model(n, BIG)));
    check("mini_timing", 32'(mi), 32'(tim_model(n, MINI)));
    check("mini_pat_sel", 32'(m_pat_sel), 32'(mdl_pat));
    if (b_pt && b_vc == 10'd1) begin
      hs_low_l1 += int'(!b_hs);
      vid_l1    += int'(b_vid);
    end
    if (m_pt) begin
      if (m_fs) begin
        if (mini_fs_seen > 0) begin
          check("mini_frame_vidon", 32'(mini_vid_cnt), 32'(MINI.hv * MINI.vv));
          check("mini_frame_period", n - last_fs_n, MINI_FRAME);
        end
        mini_fs_seen++;
        last_fs_n    = n;
        mini_vid_cnt = int'(m_vid);
      end else begin
        mini_vid_cnt += int'(m_vid);
      end
    end
  endtask

  task automatic goto(input int unsigned target);
    while (n < target) step();
  endtask

  task automatic pulse_req();
    next_req = 1'b1;
    step();
    step();
    next_req = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_big", 32'(bi), 32'(RST_TIM));
    check("rst_mini", 32'(mi), 32'(RST_TIM));
    check("rst_pat", 32'(m_pat_sel), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n        = 1'b1;
    n            = 0;
    mdl_pat      = 0;
    mdl_frames   = 0;
    mdl_pend     = 1'b0;
    mdl_nr_last  = 1'b0;
    hs_low_l1    = 0;
    vid_l1       = 0;
    mini_fs_seen = 0;
    mini_vid_cnt = 0;
    last_fs_n    = 0;
  endtask

  task automatic apply_table();
    for (int i = 0; i < 14; i++) begin
      goto(tbl[i].cyc);
      check($sformatf("table[%0d]", i), 32'(bi), 32'(tbl[i].exp));
    end
    goto(3202);
    check("line1_hsync_low_ticks", 32'(hs_low_l1), 32'd96);
    check("line1_vidon_ticks", 32'(vid_l1), 32'd640);
  endtask

  initial begin
    // Real-geometry checkpoints: {clock since reset, {hc, vc, hsync, vsync, vidon, pix_tick, frame_start}}.
    tbl[0]  = '{0,    '{10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[1]  = '{1,    '{10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[2]  = '{2,    '{10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}};
    tbl[3]  = '{3,    '{10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[4]  = '{1278, '{10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}};
    tbl[5]  = '{1280, '{10'd640, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[6]  = '{1310, '{10'd655, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[7]  = '{1312, '{10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[8]  = '{1502, '{10'd751, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[9]  = '{1504, '{10'd752, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[10] = '{1598, '{10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[11] = '{1600, '{10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}};
    tbl[12] = '{1601, '{10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[13] = '{3200, '{10'd0,   10'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}};

    // Pattern expected one clock after each frame_start k (index 0 = before the first frame ends).
    exp_pat = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 2, 2, 3, 3, 0};

    vectors     = 0;
    miscompares = 0;
    auto_en     = 1'b0;
    next_req    = 1'b0;
    rst_n       = 1'b1;
    n           = 0;
    #2;

    // Reset, divider and line timing.
    do_reset();
    apply_table();

    // Manual advance: three requests in one frame give a single step.
    do_reset();
    goto(100);
    repeat (3) begin
      next_req = 1'b1;
      step();
      step();
      next_req = 1'b0;
      step();
      step();
    end
    goto(MINI_FRAME);
    check("man_fs", 32'(m_fs), 32'd1);
    check("man_pat_at_fs", 32'(m_pat_sel), 32'd0);
    goto(MINI_FRAME + 1);
    check("man_pat_after_fs", 32'(m_pat_sel), 32'd1);
    goto(2 * MINI_FRAME + 2);
    check("man_pat_hold", 32'(m_pat_sel), 32'd1);

    // Auto cycling, simultaneous request + dwell expiry, manual advance mid-dwell, request on frame_start.
    auto_en = 1'b1;
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      if (k == 10 || k == 11) begin
        goto(MINI_FRAME * (k - 1) + 200);
        pulse_req();
      end
      if (k == 14) begin
        goto(MINI_FRAME * (k - 1) + 60);
        auto_en = 1'b0;
      end
      goto(MINI_FRAME * k);
      check($sformatf("auto_fs[%0d]", k), 32'(m_fs), 32'd1);
      check($sformatf("auto_pat_at_fs[%0d]", k), 32'(m_pat_sel), 32'(exp_pat[k-1]));
      if (k == 14) next_req = 1'b1;
      goto(MINI_FRAME * k + 1);
      check($sformatf("auto_pat[%0d]", k), 32'(m_pat_sel), 32'(exp_pat[k]));
      if (k == 14) begin
        step();
        next_req = 1'b0;
      end
    end

    // Reset mid-frame with CHECKER active, then the restart must match the first run.
    auto_en = 1'b1;
    do_reset();
    goto(4 * MINI_FRAME + 164);
    check("pre_rst_hc", 32'(m_hc), 32'd10);
    check("pre_rst_vc", 32'(m_vc), 32'd3);
    check("pre_rst_pat", 32'(m_pat_sel), 32'd2);
    auto_en = 1'b0;
    do_reset();
    apply_table();

    // Randomised requests and mode changes against the reference model.
    auto_en = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 999) < 3) next_req = ~next_req;
      if ($urandom_range(0, 999) < 1) auto_en = ~auto_en;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_frame_sequencer.md
# vga_frame_sequencer

Timing and pattern controller for the 640x480 VGA path. Generates the pixel tick, horizontal/vertical counters, sync pulses and video-enable that feed the pattern generators, and a frame-synchronous state machine choosing the active pattern via `pat_sel`. The block sits between the board clock/buttons and the pattern generators and the output colour mux.

## Interface
- `CLK_DIV`, 2: board clocks per pixel (50 MHz board clock gives a 25 MHz pixel rate); must be at least 1.
- `DWELL_FRAMES`, 120: frames each pattern is held in auto mode; must be at least 1.
- `clk`  in  1  board clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `auto_en`  in  1  level; 1 selects auto-cycle mode, 0 selects manual mode. Already synchronous to `clk`.
- `next_req`  in  1  manual advance request, already debounced and synchronous; the block acts on its rising edge.
- `hc`  out  10  horizontal count, 0..799.
- `vc`  out  10  vertical count, 0..524.
- `hsync`  out  1  active-low horizontal sync.
- `vsync`  out  1  active-low vertical sync.
- `vidon`  out  1  high in the visible area.
- `pix_tick`  out  1  one-clock strobe at each pixel advance.
- `frame_start`  out  1  one-clock strobe when the counters wrap to (0,0).
- `pat_sel`  out  2  active pattern: 0 = STRIPES, 1 = BARS, 2 = CHECKER, 3 = BLANK.

## Operation
- **Divider:** `div` counts 0..CLK_DIV-1 on every clock. `pix_tick` is 1 in the cycle where `div == CLK_DIV-1`. When CLK_DIV is 1, `pix_tick` is constantly 1 after reset.
- **Counters:** both counters change only on `pix_tick`.
  - `hc` increments and wraps from 799 to 0.
  - On the `hc` wrap, `vc` increments and wraps from 524 to 0.
- **Derived outputs:** all registered and aligned to the `hc`/`vc` values presented.
  - `vidon` = (hc < 640) and (vc < 480).
  - `hsync` = 0 when hc is in 656..751.
  - `vsync` = 0 when vc is in 490..491.
- **Edge detect:** a rising edge of `next_req` sets a `pending` flag. Further edges while `pending` is set are absorbed, so there is at most one advance per frame.
- **Dwell:** `dwell_cnt` increments on each `frame_start`. It counts only while `auto_en` is 1 and clears while `auto_en` is 0.
- **Pattern FSM:** states STRIPES -> BARS -> CHECKER -> BLANK -> STRIPES.
  - The FSM transitions only in the cycle `frame_start` is 1, so `pat_sel` never changes mid-frame.
  - It advances one step when `pending` is set, or when `auto_en` is 1 and `dwell_cnt == DWELL_FRAMES-1`.
  - If both conditions hold in the same frame, it advances exactly once.
  - Any advance clears `pending` and `dwell_cnt`.
- **`auto_en` toggling:** changing `auto_en` mid-frame takes effect at the next `frame_start`. Dwell restarts from 0.

## Timing
- **Reset values:**
  - `hc` = 0, `vc` = 0, `div` = 0.
  - `hsync` = 1, `vsync` = 1, `vidon` = 1 (the (0,0) pixel is visible).
  - `pix_tick` = 0, `frame_start` = 0.
  - `pat_sel` = 0 (STRIPES).
  - `pending` = 0, `dwell_cnt` = 0.
- **Reset mid-frame:** all state returns to the reset values immediately (asynchronously). The first `pix_tick` occurs CLK_DIV clocks after `rst_n` deasserts.
- **Frame period:** 800 x 525 pixel ticks = 420000 x CLK_DIV clocks.
- **`frame_start` strobe:** high in the clock where `hc`/`vc` become (0,0), i.e. the same edge that registers the wrap.
- **Pattern change latency:** `pat_sel` updates on the clock after `frame_start`, before the first pixel of the new frame is displayed. This holds whenever CLK_DIV >= 2. When CLK_DIV is 1, pixel (0,0) of the new frame still shows the old pattern; this is accepted.
- **Request timing:** a `next_req` edge in the same clock as `frame_start` is recorded, but it advances the pattern one frame later.
- **Output register stage:** all outputs are registered, with no combinational path from inputs to outputs.

## Structure
- **Package `vga_pkg`:**
  - Timing constants H_VISIBLE 640, H_SYNC_START 656, H_SYNC_END 751, H_TOTAL 800, V_VISIBLE 480, V_SYNC_START 490, V_SYNC_END 491, V_TOTAL 525.
  - The `pat_t` enum for the four patterns.
- **Sub-module `vga_timing`:** holds the divider, counters, sync, `vidon` and `frame_start`.
- **Top level:** holds the edge detector, dwell counter and pattern FSM.

## Test plan
- **Reset and divider:** CLK_DIV=2, release reset.
  - `pix_tick` is seen every 2nd clock.
  - `hc` reaches 799, then 0 on the next tick, while `vc` goes 0 -> 1.
  - `hsync` is low for exactly 96 ticks starting at hc=656.
- **Full frame:** run one full frame.
  - `vsync` is low only for vc=490..491.
  - `vidon` is high for exactly 640x480 = 307200 ticks.
  - `frame_start` pulses once per 840000 clocks.
- **Manual advance:** `auto_en`=0, three `next_req` pulses in mid-frame.
  - `pat_sel` goes 0 -> 1 only, one clock after the next `frame_start`.
  - No further change occurs without new requests.
- **Auto cycling:** `auto_en`=1, DWELL_FRAMES=2.
  - `pat_sel` steps 0,1,2,3,0 every 2 frames.
  - It wraps from BLANK to STRIPES.
- **Simultaneous events:** `next_req` edge in the frame where the dwell expires -> a single advance and `dwell_cnt` = 0.
- **Reset mid-frame:** assert `rst_n` at hc=300, vc=200 with `pat_sel`=2.
  - All outputs take their reset values immediately.
  - The restart matches the first scenario.
